// File: rtl/mem_req_pkg.sv
// ---------------------------------------------------------------------------
// mem_req_pkg
// Shared definitions for the data-side request issuer:
//   - MEMOP_* load/store op encodings driven by EXE
//   - SIZE_* bus transfer size codes
//   - req_state_t FSM state type
//   - decode_op(): op/offset/rt -> write flag, size, byte strobes, lane data
// ---------------------------------------------------------------------------
package mem_req_pkg;

    localparam logic [3:0] MEMOP_LB  = 4'd0;
    localparam logic [3:0] MEMOP_LBU = 4'd1;
    localparam logic [3:0] MEMOP_LH  = 4'd2;
    localparam logic [3:0] MEMOP_LHU = 4'd3;
    localparam logic [3:0] MEMOP_LW  = 4'd4;
    localparam logic [3:0] MEMOP_LWL = 4'd5;
    localparam logic [3:0] MEMOP_LWR = 4'd6;
    localparam logic [3:0] MEMOP_SB  = 4'd8;
    localparam logic [3:0] MEMOP_SH  = 4'd9;
    localparam logic [3:0] MEMOP_SW  = 4'd10;
    localparam logic [3:0] MEMOP_SWL = 4'd11;
    localparam logic [3:0] MEMOP_SWR = 4'd12;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } req_state_t;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic        word_align;   // bus address forced to a word boundary
    } req_fields_t;

    function automatic req_fields_t decode_op(input logic [3:0]  op,
                                              input logic [1:0]  ofs,
                                              input logic [31:0] rt);
        req_fields_t f;
        f      = '0;
        f.size = SIZE_WORD;
        case (op)
            MEMOP_LB, MEMOP_LBU: f.size = SIZE_BYTE;
            MEMOP_LH, MEMOP_LHU: f.size = SIZE_HALF;
            MEMOP_LWL, MEMOP_LWR: f.word_align = 1'b1;
            MEMOP_SB: begin
                f.wr    = 1'b1;
                f.size  = SIZE_BYTE;
                f.wstrb = 4'b0001 << ofs;
                f.wdata = {4{rt[7:0]}};
            end
            MEMOP_SH: begin
                f.wr    = 1'b1;
                f.size  = SIZE_HALF;
                f.wstrb = ofs[1] ? 4'b1100 : 4'b0011;
                f.wdata = {2{rt[15:0]}};
            end
            MEMOP_SW: begin
                f.wr    = 1'b1;
                f.wstrb = 4'b1111;
                f.wdata = rt;
            end
            MEMOP_SWL: begin
                f.wr         = 1'b1;
                f.word_align = 1'b1;
                case (ofs)
                    2'd0: begin f.wstrb = 4'b0001; f.wdata = {24'd0, rt[31:24]}; end
                    2'd1: begin f.wstrb = 4'b0011; f.wdata = {16'd0, rt[31:16]}; end
                    2'd2: begin f.wstrb = 4'b0111; f.wdata = {8'd0,  rt[31:8]};  end
                    default: begin f.wstrb = 4'b1111; f.wdata = rt; end
                endcase
            end
            MEMOP_SWR: begin
                f.wr         = 1'b1;
                f.word_align = 1'b1;
                case (ofs)
                    2'd0: begin f.wstrb = 4'b1111; f.wdata = rt; end
                    2'd1: begin f.wstrb = 4'b1110; f.wdata = {rt[23:0], 8'd0};  end
                    2'd2: begin f.wstrb = 4'b1100; f.wdata = {rt[15:0], 16'd0}; end
                    default: begin f.wstrb = 4'b1000; f.wdata = {rt[7:0], 24'd0}; end
                endcase
            end
            default: ;   // LW and unused codes: plain word load
        endcase
        return f;
    endfunction

endpackage

// File: rtl/data_req_ctrl_if.sv
// ---------------------------------------------------------------------------
// data_req_ctrl_if
// SRAM-like data bus between the request issuer (master) and memory (slave).
//   data_req/data_wr/data_size/data_wstrb/data_addr/data_wdata : request
//   data_addr_ok : address accepted, data_data_ok/data_rdata : response
// ---------------------------------------------------------------------------
interface data_req_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              data_req;
    logic              data_wr;
    logic [1:0]        data_size;
    logic [3:0]        data_wstrb;
    logic [ADDR_W-1:0] data_addr;
    logic [31:0]       data_wdata;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [31:0]       data_rdata;

    modport master (
        output data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata
    );

    modport slave (
        input  data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata
    );
endinterface

// File: rtl/data_rsp_fifo.sv
// ---------------------------------------------------------------------------
// data_rsp_fifo
// In-order response buffer, DEPTH x 32 bit, synchronous clear.
//   clk, resetn : clock, synchronous active-low reset
//   i_clr       : drop all contents (wins over push/pop)
//   i_push/i_wdata : write one entry
//   i_pop       : consume head (ignored when empty)
//   o_rdata     : head entry, o_count : number of stored entries
// ---------------------------------------------------------------------------
module data_rsp_fifo #(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_clr,
    input  logic             i_push,
    input  logic [31:0]      i_wdata,
    input  logic             i_pop,
    output logic [31:0]      o_rdata,
    output logic [CNT_W-1:0] o_count
);
    localparam int               PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

    logic [31:0]      r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign w_pop  = i_pop & (r_count != '0);
    // a full FIFO still accepts a push when the head leaves in the same cycle
    assign w_push = i_push & ((r_count != FULL) | w_pop);

    always_ff @(posedge clk) begin
        if (!resetn || i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= (r_wr_ptr == LAST) ? '0 : r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= (r_rd_ptr == LAST) ? '0 : r_rd_ptr + 1'b1;
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !i_clr) r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;

    a_no_overflow: assert property (@(posedge clk) disable iff (!resetn)
        !(i_push && !i_clr && !w_pop && r_count == FULL));

endmodule

// File: rtl/data_req_ctrl.sv
// ---------------------------------------------------------------------------
// data_req_ctrl
// Data-side request issuer at the EXE/MEM boundary. Turns EXE load/store ops
// into SRAM-like bus requests, counts outstanding transactions, buffers
// responses in order for MEM and drops responses of flushed requests.
//
// Ports:
//   clk, resetn          : clock, synchronous active-low reset
//   es_req_valid/ready   : EXE op handshake (ready = addr accepted or es_ex bypass)
//   es_op/es_vaddr/es_rt_value/es_ex : op fields from EXE
//   flush                : WB exception/eret kill
//   bus (master)         : data_req/wr/size/wstrb/addr/wdata, addr_ok, data_ok, rdata
//   ms_rsp_valid/rdata/ready : in-order response stream to MEM
//   busy                 : outstanding or buffered transactions present
// Build option:
//   DATA_REQ_PERF_EN     : adds perf_req_cnt / perf_stall_cnt counters
//
// FSM states:
//   state   | meaning
//   ST_IDLE | no request held; a new op may drive data_req combinationally
//   ST_REQ  | request presented but not yet accepted; fields replayed from regs
// ---------------------------------------------------------------------------
module data_req_ctrl
    import mem_req_pkg::*;
#(
    parameter int MAX_OUTST = 2,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              es_req_valid,
    output logic              es_req_ready,
    input  logic [3:0]        es_op,
    input  logic [ADDR_W-1:0] es_vaddr,
    input  logic [31:0]       es_rt_value,
    input  logic              es_ex,
    input  logic              flush,
    data_req_ctrl_if.master   bus,
    output logic              ms_rsp_valid,
    output logic [31:0]       ms_rsp_rdata,
    input  logic              ms_rsp_ready,
    output logic              busy
`ifdef DATA_REQ_PERF_EN
    ,
    output logic [31:0]       perf_req_cnt,
    output logic [31:0]       perf_stall_cnt
`endif
);
    localparam int             CNT_W = $clog2(MAX_OUTST + 1);
    localparam int             SUM_W = CNT_W + 1;
    localparam logic [SUM_W-1:0] LIMIT = SUM_W'(MAX_OUTST);

    req_state_t        r_state;
    req_state_t        w_state_nxt;
    logic              r_wr;
    logic [1:0]        r_size;
    logic [3:0]        r_wstrb;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_kill_pend;
    logic [CNT_W-1:0]  r_outst_cnt;
    logic [CNT_W-1:0]  r_discard_cnt;
    logic [CNT_W-1:0]  w_outst_nxt;
    logic [CNT_W-1:0]  w_fifo_cnt;
    logic [SUM_W-1:0]  w_inflight;
    req_fields_t       w_dec;
    logic [ADDR_W-1:0] w_es_addr;
    logic              w_can_issue;
    logic              w_req;
    logic              w_wr;
    logic [1:0]        w_size;
    logic [3:0]        w_wstrb;
    logic [ADDR_W-1:0] w_addr;
    logic [31:0]       w_wdata;
    logic              w_hs;
    logic              w_drop;
    logic              w_push;
    logic              w_pop;
    logic              w_fifo_valid;

    assign w_dec     = decode_op(es_op, es_vaddr[1:0], es_rt_value);
    assign w_es_addr = w_dec.word_align ? {es_vaddr[ADDR_W-1:2], 2'b00} : es_vaddr;

    // Buffered responses count against the limit too, so a FIFO push can
    // never find the buffer full.
    assign w_inflight  = {1'b0, r_outst_cnt} + {1'b0, w_fifo_cnt};
    assign w_can_issue = es_req_valid & ~es_ex & ~flush & (w_inflight < LIMIT);

    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        w_wr        = 1'b0;
        w_size      = '0;
        w_wstrb     = '0;
        w_addr      = '0;
        w_wdata     = '0;
        if (resetn) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_can_issue) begin
                        w_req   = 1'b1;
                        w_wr    = w_dec.wr;
                        w_size  = w_dec.size;
                        w_wstrb = w_dec.wstrb;
                        w_addr  = w_es_addr;
                        w_wdata = w_dec.wdata;
                        if (!bus.data_addr_ok) w_state_nxt = ST_REQ;
                    end
                end
                ST_REQ: begin
                    // held even across a flush: the bus never sees a withdrawn request
                    w_req   = 1'b1;
                    w_wr    = r_wr;
                    w_size  = r_size;
                    w_wstrb = r_wstrb;
                    w_addr  = r_addr;
                    w_wdata = r_wdata;
                    if (bus.data_addr_ok) w_state_nxt = ST_IDLE;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wr    <= 1'b0;
            r_size  <= '0;
            r_wstrb <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (r_state == ST_IDLE && w_can_issue) begin
            r_wr    <= w_dec.wr;
            r_size  <= w_dec.size;
            r_wstrb <= w_dec.wstrb;
            r_addr  <= w_es_addr;
            r_wdata <= w_dec.wdata;
        end
    end

    assign bus.data_req   = w_req;
    assign bus.data_wr    = w_wr;
    assign bus.data_size  = w_size;
    assign bus.data_wstrb = w_wstrb;
    assign bus.data_addr  = w_addr;
    assign bus.data_wdata = w_wdata;

    assign w_hs = w_req & bus.data_addr_ok;

    // A killed request still finishes its address phase but must not tell EXE
    // it was consumed.
    assign es_req_ready = resetn &
                          ((w_hs & ~r_kill_pend & ~flush) |
                           (es_req_valid & es_ex & (r_state == ST_IDLE)));

    always_ff @(posedge clk) begin
        if (!resetn)                   r_kill_pend <= 1'b0;
        else if (r_state == ST_REQ) begin
            if (w_hs)                  r_kill_pend <= 1'b0;
            else if (flush)            r_kill_pend <= 1'b1;
        end
    end

    assign w_outst_nxt = r_outst_cnt + CNT_W'(w_hs) - CNT_W'(bus.data_data_ok);
    assign w_drop      = bus.data_data_ok & (r_discard_cnt != '0);
    assign w_push      = bus.data_data_ok & (r_discard_cnt == '0);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_outst_cnt   <= '0;
            r_discard_cnt <= '0;
        end else begin
            r_outst_cnt <= w_outst_nxt;
            // Everything still in flight after a flush belongs to killed work;
            // requests killed mid-address-phase are added when they complete.
            if (flush)
                r_discard_cnt <= w_outst_nxt;
            else
                r_discard_cnt <= r_discard_cnt + CNT_W'(w_hs & r_kill_pend) - CNT_W'(w_drop);
        end
    end

    assign w_pop = ms_rsp_ready & w_fifo_valid;

    data_rsp_fifo #(
        .DEPTH (MAX_OUTST),
        .CNT_W (CNT_W)
    ) u_rsp_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .i_clr   (flush),
        .i_push  (w_push),
        .i_wdata (bus.data_rdata),
        .i_pop   (w_pop),
        .o_rdata (ms_rsp_rdata),
        .o_count (w_fifo_cnt)
    );

    assign w_fifo_valid = resetn & (w_fifo_cnt != '0);
    assign ms_rsp_valid = w_fifo_valid;
    assign busy         = resetn & ((r_outst_cnt != '0) | (w_fifo_cnt != '0));

`ifdef DATA_REQ_PERF_EN
    logic [31:0] r_perf_req_cnt;
    logic [31:0] r_perf_stall_cnt;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_perf_req_cnt   <= '0;
            r_perf_stall_cnt <= '0;
        end else begin
            if (w_hs)                          r_perf_req_cnt   <= r_perf_req_cnt + 32'd1;
            if (es_req_valid && !es_req_ready) r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
        end
    end

    assign perf_req_cnt   = r_perf_req_cnt;
    assign perf_stall_cnt = r_perf_stall_cnt;
`endif

endmodule

// File: tb/tb_data_req_ctrl.sv
// ---------------------------------------------------------------------------
// tb_data_req_ctrl
// Directed bench for data_req_ctrl with MAX_OUTST=2; the bench plays the
// memory side of the bus and the MEM consumer.
// ---------------------------------------------------------------------------
module tb_data_req_ctrl;
    import mem_req_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        es_req_valid;
    logic        es_req_ready;
    logic [3:0]  es_op;
    logic [31:0] es_vaddr;
    logic [31:0] es_rt_value;
    logic        es_ex;
    logic        flush;
    logic        ms_rsp_valid;
    logic [31:0] ms_rsp_rdata;
    logic        ms_rsp_ready;
    logic        busy;
`ifdef DATA_REQ_PERF_EN
    logic [31:0] perf_req_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    data_req_ctrl_if #(.ADDR_W(32)) bus ();

    data_req_ctrl #(
        .MAX_OUTST (2),
        .ADDR_W    (32)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .es_req_valid   (es_req_valid),
        .es_req_ready   (es_req_ready),
        .es_op          (es_op),
        .es_vaddr       (es_vaddr),
        .es_rt_value    (es_rt_value),
        .es_ex          (es_ex),
        .flush          (flush),
        .bus            (bus),
        .ms_rsp_valid   (ms_rsp_valid),
        .ms_rsp_rdata   (ms_rsp_rdata),
        .ms_rsp_ready   (ms_rsp_ready),
        .busy           (busy)
`ifdef DATA_REQ_PERF_EN
        ,
        .perf_req_cnt   (perf_req_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present an op with addr_ok already high; it must be accepted this cycle.
    task automatic issue_imm(input string tag, input logic [3:0] op, input logic [31:0] va,
                             input logic [31:0] rt, input logic exp_wr, input logic [1:0] exp_size,
                             input logic [3:0] exp_strb, input logic [31:0] exp_addr,
                             input logic [31:0] exp_wdata);
        es_req_valid     = 1'b1;
        es_op            = op;
        es_vaddr         = va;
        es_rt_value      = rt;
        bus.data_addr_ok = 1'b1;
        #1;
        check_val({tag, "_req"},   bus.data_req,   1);
        check_val({tag, "_ready"}, es_req_ready,   1);
        check_val({tag, "_wr"},    bus.data_wr,    exp_wr);
        check_val({tag, "_size"},  bus.data_size,  exp_size);
        check_val({tag, "_wstrb"}, bus.data_wstrb, exp_strb);
        check_val({tag, "_addr"},  bus.data_addr,  exp_addr);
        if (exp_wr) check_val({tag, "_wdata"}, bus.data_wdata, exp_wdata);
        step();
        es_req_valid     = 1'b0;
        bus.data_addr_ok = 1'b0;
    endtask

    task automatic respond(input logic [31:0] rd);
        bus.data_data_ok = 1'b1;
        bus.data_rdata   = rd;
        step();
        bus.data_data_ok = 1'b0;
    endtask

    task automatic pop_chk(input string tag, input logic [31:0] exp);
        ms_rsp_ready = 1'b1;
        #1;
        check_val({tag, "_valid"}, ms_rsp_valid, 1);
        check_val({tag, "_rdata"}, ms_rsp_rdata, exp);
        step();
        ms_rsp_ready = 1'b0;
    endtask

    initial begin
        resetn           = 1'b0;
        es_req_valid     = 1'b1;
        es_ex            = 1'b1;
        es_op            = MEMOP_LW;
        es_vaddr         = 32'h0;
        es_rt_value      = 32'h0;
        flush            = 1'b0;
        ms_rsp_ready     = 1'b0;
        bus.data_addr_ok = 1'b0;
        bus.data_data_ok = 1'b0;
        bus.data_rdata   = 32'h0;

        // outputs held low during reset, even with an es_ex op pending
        step();
        step();
        check_val("rst_req",   bus.data_req, 0);
        check_val("rst_ready", es_req_ready, 0);
        check_val("rst_busy",  busy,         0);
        check_val("rst_rspv",  ms_rsp_valid, 0);
        es_req_valid = 1'b0;
        es_ex        = 1'b0;
        resetn       = 1'b1;
        step();

        // SW with addr_ok delayed 3 cycles
        es_req_valid = 1'b1;
        es_op        = MEMOP_SW;
        es_vaddr     = 32'h0000_1000;
        es_rt_value  = 32'h1234_5678;
        #1;
        check_val("sw_c0_req",   bus.data_req,   1);
        check_val("sw_c0_ready", es_req_ready,   0);
        check_val("sw_c0_wr",    bus.data_wr,    1);
        check_val("sw_c0_wstrb", bus.data_wstrb, 4'b1111);
        check_val("sw_c0_addr",  bus.data_addr,  32'h0000_1000);
        check_val("sw_c0_wdata", bus.data_wdata, 32'h1234_5678);
        step();
        es_vaddr    = 32'hDEAD_0000;
        es_rt_value = 32'h0;
        for (int i = 1; i < 3; i++) begin
            #1;
            check_val("sw_hold_req",   bus.data_req,   1);
            check_val("sw_hold_ready", es_req_ready,   0);
            check_val("sw_hold_addr",  bus.data_addr,  32'h0000_1000);
            check_val("sw_hold_wdata", bus.data_wdata, 32'h1234_5678);
            check_val("sw_hold_wstrb", bus.data_wstrb, 4'b1111);
            step();
        end
        bus.data_addr_ok = 1'b1;
        #1;
        check_val("sw_c3_req",   bus.data_req,  1);
        check_val("sw_c3_ready", es_req_ready,  1);
        check_val("sw_c3_addr",  bus.data_addr, 32'h0000_1000);
        step();
        es_req_valid     = 1'b0;
        bus.data_addr_ok = 1'b0;
        #1;
        check_val("sw_after_req",  bus.data_req, 0);
        check_val("sw_after_busy", busy,         1);
        check_val("sw_after_rspv", ms_rsp_valid, 0);
        respond(32'h5A5A_5A5A);
        pop_chk("sw_rsp", 32'h5A5A_5A5A);
        check_val("sw_done_rspv", ms_rsp_valid, 0);
        check_val("sw_done_busy", busy,         0);

        // lane steering
        issue_imm("sb",  MEMOP_SB,  32'h0000_1003, 32'h0000_00AB, 1'b1, SIZE_BYTE, 4'b1000, 32'h0000_1003, 32'hABAB_ABAB);
        issue_imm("swr", MEMOP_SWR, 32'h0000_2002, 32'h1122_3344, 1'b1, SIZE_WORD, 4'b1100, 32'h0000_2000, 32'h3344_0000);
        respond(32'h0000_0001);
        respond(32'h0000_0002);
        pop_chk("lane_rsp1", 32'h0000_0001);
        pop_chk("lane_rsp2", 32'h0000_0002);
        issue_imm("sh",  MEMOP_SH,  32'h0000_1002, 32'h0000_BEEF, 1'b1, SIZE_HALF, 4'b1100, 32'h0000_1002, 32'hBEEF_BEEF);
        issue_imm("swl", MEMOP_SWL, 32'h0000_2001, 32'h1122_3344, 1'b1, SIZE_WORD, 4'b0011, 32'h0000_2000, 32'h0000_1122);
        respond(32'h0000_0003);
        respond(32'h0000_0004);
        pop_chk("lane_rsp3", 32'h0000_0003);
        pop_chk("lane_rsp4", 32'h0000_0004);
        check_val("lane_busy", busy, 0);

        // outstanding limit: third LW waits for a pop
        issue_imm("lw1", MEMOP_LW, 32'h0000_0100, 32'h0, 1'b0, SIZE_WORD, 4'b0000, 32'h0000_0100, 32'h0);
        issue_imm("lw2", MEMOP_LW, 32'h0000_0104, 32'h0, 1'b0, SIZE_WORD, 4'b0000, 32'h0000_0104, 32'h0);
        es_req_valid     = 1'b1;
        es_op            = MEMOP_LW;
        es_vaddr         = 32'h0000_0108;
        bus.data_addr_ok = 1'b1;
        #1;
        check_val("lim_blk0_req",   bus.data_req, 0);
        check_val("lim_blk0_ready", es_req_ready, 0);
        respond(32'hAAAA_0001);
        check_val("lim_blk1_req", bus.data_req, 0);
        respond(32'hAAAA_0002);
        check_val("lim_blk2_req", bus.data_req, 0);
        ms_rsp_ready = 1'b1;
        #1;
        check_val("lim_pop_rdata", ms_rsp_rdata, 32'hAAAA_0001);
        check_val("lim_pop_req",   bus.data_req, 0);
        step();
        ms_rsp_ready = 1'b0;
        #1;
        check_val("lim_go_req",   bus.data_req,  1);
        check_val("lim_go_addr",  bus.data_addr, 32'h0000_0108);
        check_val("lim_go_ready", es_req_ready,  1);
        step();
        es_req_valid     = 1'b0;
        bus.data_addr_ok = 1'b0;
        respond(32'hAAAA_0003);
        pop_chk("lim_rsp2", 32'hAAAA_0002);
        pop_chk("lim_rsp3", 32'hAAAA_0003);

        // flush after issue: response dropped
        issue_imm("fl_lw", MEMOP_LW, 32'h0000_0200, 32'h0, 1'b0, SIZE_WORD, 4'b0000, 32'h0000_0200, 32'h0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        #1;
        check_val("fl_busy_pre", busy, 1);
        respond(32'hDEAD_0000);
        check_val("fl_rspv", ms_rsp_valid, 0);
        check_val("fl_busy", busy,         0);

        // flush while the address phase is pending
        es_req_valid = 1'b1;
        es_op        = MEMOP_LW;
        es_vaddr     = 32'h0000_0300;
        step();
        flush = 1'b1;
        #1;
        check_val("flreq_f_req",   bus.data_req, 1);
        check_val("flreq_f_ready", es_req_ready, 0);
        step();
        flush            = 1'b0;
        es_req_valid     = 1'b0;
        bus.data_addr_ok = 1'b1;
        #1;
        check_val("flreq_hs_req",   bus.data_req,  1);
        check_val("flreq_hs_addr",  bus.data_addr, 32'h0000_0300);
        check_val("flreq_hs_ready", es_req_ready,  0);
        step();
        bus.data_addr_ok = 1'b0;
        #1;
        check_val("flreq_busy_pre", busy, 1);
        respond(32'h0BAD_0000);
        check_val("flreq_rspv", ms_rsp_valid, 0);
        check_val("flreq_busy", busy,         0);
        issue_imm("flreq_next", MEMOP_LW, 32'h0000_0400, 32'h0, 1'b0, SIZE_WORD, 4'b0000, 32'h0000_0400, 32'h0);
        respond(32'h600D_0000);
        pop_chk("flreq_next_rsp", 32'h600D_0000);

        // es_ex bypass
        es_req_valid = 1'b1;
        es_ex        = 1'b1;
        es_op        = MEMOP_LW;
        es_vaddr     = 32'h0000_0003;
        #1;
        check_val("ex_ready", es_req_ready, 1);
        check_val("ex_req",   bus.data_req, 0);
        step();
        es_req_valid = 1'b0;
        es_ex        = 1'b0;
        #1;
        check_val("ex_busy", busy, 0);

        // flush in IDLE suppresses the same-cycle request
        es_req_valid     = 1'b1;
        es_vaddr         = 32'h0000_0500;
        flush            = 1'b1;
        bus.data_addr_ok = 1'b1;
        #1;
        check_val("fli_req",   bus.data_req, 0);
        check_val("fli_ready", es_req_ready, 0);
        step();
        es_req_valid     = 1'b0;
        flush            = 1'b0;
        bus.data_addr_ok = 1'b0;
        #1;
        check_val("fli_busy", busy, 0);

        // reset in the middle of a transaction
        issue_imm("rm_lw", MEMOP_LW, 32'h0000_0600, 32'h0, 1'b0, SIZE_WORD, 4'b0000, 32'h0000_0600, 32'h0);
        es_req_valid = 1'b1;
        es_vaddr     = 32'h0000_0604;
        step();
        resetn = 1'b0;
        #1;
        check_val("rm_in_req",  bus.data_req, 0);
        check_val("rm_in_busy", busy,         0);
        step();
        resetn       = 1'b1;
        es_req_valid = 1'b0;
        #1;
        check_val("rm_out_req",  bus.data_req, 0);
        check_val("rm_out_busy", busy,         0);
        check_val("rm_out_rspv", ms_rsp_valid, 0);
        issue_imm("rm_next", MEMOP_LW, 32'h0000_0700, 32'h0, 1'b0, SIZE_WORD, 4'b0000, 32'h0000_0700, 32'h0);
        respond(32'h0000_0077);
        pop_chk("rm_next_rsp", 32'h0000_0077);
        check_val("end_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
